load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, lane-aligned memory access with
// byte enables, sign/zero-extended load results, timeout and error reporting.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_done,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic [1:0]        dbg_state
);
    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_SIZE = 2'b11;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready is high only in IDLE and never in reset.
    logic [1:0]       state_q, state_d;
    logic             store_q, store_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [XLEN-1:OW] addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [OW-1:0]    off_q, off_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [1:0]       err_q, err_d;

    logic             in_access;
    logic             illegal_in, misal_in;
    logic [OW-1:0]    align_mask;
    logic [BW-1:0]    be_base;
    logic [XLEN-1:0]  shifted, size_mask, load_ext;
    logic             sign_bit;

    assign in_access  = (state_q == S_ACCESS);
    assign align_mask = OW'((4'd1 << req_size) - 4'd1);
    assign illegal_in = (req_size == 2'b11) && (XLEN == 32);
    assign misal_in   = (req_addr[OW-1:0] & align_mask) != '0;

    always_comb begin
        case (size_q)
            2'd0:    be_base = BW'(8'h01);
            2'd1:    be_base = BW'(8'h03);
            2'd2:    be_base = BW'(8'h0F);
            default: be_base = '1;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then size and extend.
    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    begin size_mask = XLEN'(8'hFF);         sign_bit = shifted[7];      end
            2'd1:    begin size_mask = XLEN'(16'hFFFF);      sign_bit = shifted[15];     end
            2'd2:    begin size_mask = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31];     end
            default: begin size_mask = '1;                   sign_bit = shifted[XLEN-1]; end
        endcase
        load_ext = (shifted & size_mask) | ((sign_bit && !uns_q) ? ~size_mask : '0);
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[XLEN-1:OW];
                    wdata_d = req_wdata;
                    off_d   = req_addr[OW-1:0];
                    cnt_d   = '0;
                    if (illegal_in) begin
                        state_d = S_RESP;
                        err_d   = ERR_SIZE;
                        rdata_d = '0;
                    end else if (misal_in) begin
                        state_d = S_RESP;
                        err_d   = ERR_MIS;
                        rdata_d = '0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // Completion is checked before the timeout so a late done still wins.
                if (mem_done) begin
                    state_d = S_RESP;
                    err_d   = ERR_OK;
                    rdata_d = store_q ? '0 : load_ext;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    err_d   = ERR_TMO;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            store_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign mem_req    = in_access;
    assign mem_we     = in_access && store_q;
    assign mem_addr   = in_access ? {addr_q, {OW{1'b0}}} : '0;
    assign mem_be     = in_access ? (be_base << off_q) : '0;
    assign mem_wdata  = in_access ? (wdata_q << {off_q, 3'b000}) : '0;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit (TIMEOUT=4) and a 64-bit instance share
// request/memory inputs; each transaction is scored against a byte-level model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid32 = 1'b0, req_valid64 = 1'b0;
    logic        req_store = 1'b0, req_unsigned = 1'b0, mem_done = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [63:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;

    logic        ready32, mreq32, mwe32, rv32;
    logic [31:0] maddr32, mwd32, rrd32;
    logic [3:0]  mbe32;
    logic [1:0]  rerr32, st32;
    logic        ready64, mreq64, mwe64, rv64;
    logic [63:0] maddr64, mwd64, rrd64;
    logic [7:0]  mbe64;
    logic [1:0]  rerr64, st64;

    int total = 0;
    int bad = 0;
    bit cur = 1'b0;

    load_store_unit #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid32), .req_ready(ready32),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .mem_req(mreq32), .mem_we(mwe32), .mem_addr(maddr32), .mem_be(mbe32),
        .mem_wdata(mwd32), .mem_rdata(mem_rdata[31:0]), .mem_done(mem_done),
        .resp_valid(rv32), .resp_rdata(rrd32), .resp_err(rerr32), .dbg_state(st32)
    );

    load_store_unit #(.XLEN(64), .TIMEOUT(15)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid64), .req_ready(ready64),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mreq64), .mem_we(mwe64), .mem_addr(maddr64), .mem_be(mbe64),
        .mem_wdata(mwd64), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .resp_valid(rv64), .resp_rdata(rrd64), .resp_err(rerr64), .dbg_state(st64)
    );

    always #5 clk = ~clk;

    logic        o_ready, o_mreq, o_mwe, o_rv;
    logic [63:0] o_addr, o_wd, o_rd;
    logic [7:0]  o_be;
    logic [1:0]  o_err;
    assign o_ready = cur ? ready64 : ready32;
    assign o_mreq  = cur ? mreq64 : mreq32;
    assign o_mwe   = cur ? mwe64 : mwe32;
    assign o_rv    = cur ? rv64 : rv32;
    assign o_addr  = cur ? maddr64 : {32'b0, maddr32};
    assign o_wd    = cur ? mwd64 : {32'b0, mwd32};
    assign o_rd    = cur ? rrd64 : {32'b0, rrd32};
    assign o_be    = cur ? mbe64 : {4'b0, mbe32};
    assign o_err   = cur ? rerr64 : rerr32;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // delay = ACCESS cycle (1-based) in which mem_done is raised; above TIMEOUT means never.
    task automatic do_req(input bit sel, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] rd, input int delay);
        int xb, tmo, off, nb, exp_err, exp_mc, mc;
        bit got;
        logic [63:0] xmask, m, v, exp_rd, exp_be, exp_wd, exp_ad;
        xb    = sel ? 8 : 4;
        tmo   = sel ? 15 : 4;
        xmask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        off   = int'(addr[2:0]) & (xb - 1);
        nb    = 1 << sz;
        if (sz == 2'b11 && !sel)       exp_err = 3;
        else if ((off % nb) != 0)      exp_err = 1;
        else if (delay <= tmo)         exp_err = 0;
        else                           exp_err = 2;
        exp_mc = (exp_err == 0) ? delay : (exp_err == 2) ? tmo : 0;
        m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v = (rd >> (8 * off)) & m;
        if (!uns && v[8 * nb - 1]) v = v | ~m;
        exp_rd = (exp_err == 0 && !st) ? (v & xmask) : 64'd0;
        exp_be = ((64'd1 << nb) - 64'd1) << off;
        exp_wd = (wd << (8 * off)) & xmask;
        exp_ad = addr & ~64'(xb - 1) & xmask;

        cur = sel;
        @(negedge clk);
        check("ready_idle", {63'b0, o_ready}, 64'd1);
        req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        if (sel) req_valid64 = 1'b1; else req_valid32 = 1'b1;
        @(posedge clk); #1;
        req_valid32 = 1'b0; req_valid64 = 1'b0;
        req_addr = rnd64(); req_wdata = rnd64(); req_size = 2'($urandom_range(0, 3));
        mc = 0; got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (o_mreq) begin
                mc++;
                if (mc == 1) begin
                    check("mem_addr", o_addr, exp_ad);
                    check("mem_be", {56'b0, o_be}, exp_be);
                    check("mem_we", {63'b0, o_mwe}, {63'b0, st});
                    if (st) check("mem_wdata", o_wd, exp_wd);
                end
                mem_done  = (mc == delay);
                mem_rdata = (mc == delay) ? rd : rnd64();
            end else begin
                mem_done  = 1'($urandom_range(0, 1));
                mem_rdata = rnd64();
            end
            if (o_rv) begin
                got = 1'b1;
                check("resp_cycle", 64'(k), 64'(exp_mc + 1));
                check("mem_cycles", 64'(mc), 64'(exp_mc));
                check("resp_err", {62'b0, o_err}, 64'(exp_err));
                check("resp_rdata", o_rd, exp_rd);
            end
        end
        if (!got) check("resp_seen", 64'd0, 64'd1);
        mem_done = 1'b0;
        @(posedge clk); #1;
        check("resp_one_cycle", {63'b0, o_rv}, 64'd0);
        check("resp_err_hold", {62'b0, o_err}, 64'(exp_err));
    endtask

    initial begin
        int seen;
        // reset state
        #12;
        cur = 1'b0;
        check("rst_ready", {63'b0, o_ready}, 64'd0);
        check("rst_mem_req", {63'b0, o_mreq}, 64'd0);
        check("rst_mem_be", {56'b0, o_be}, 64'd0);
        check("rst_mem_addr", o_addr, 64'd0);
        check("rst_mem_wdata", o_wd, 64'd0);
        check("rst_resp_valid", {63'b0, o_rv}, 64'd0);
        check("rst_resp_err", {62'b0, o_err}, 64'd0);
        check("rst_resp_rdata", o_rd, 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);

        // directed cases
        do_req(0, 1, 2'd0, 0, 64'h103, 64'hAB, 64'h0, 2);
        check("dir_store_be", {56'b0, mbe32}, 64'd0);
        do_req(0, 0, 2'd1, 0, 64'h202, 64'h0, 64'h8001_1234, 1);
        check("dir_half_signed", {32'b0, rrd32}, 64'hFFFF_8001);
        do_req(0, 0, 2'd1, 1, 64'h202, 64'h0, 64'h8001_1234, 3);
        check("dir_half_unsigned", {32'b0, rrd32}, 64'h0000_8001);
        do_req(0, 0, 2'd2, 0, 64'h105, 64'h0, 64'h0, 1);
        do_req(0, 0, 2'd2, 0, 64'h100, 64'h0, 64'h1234_5678, 99);
        do_req(0, 0, 2'd2, 0, 64'h100, 64'h0, 64'h1234_5678, 4);
        do_req(0, 0, 2'd3, 0, 64'h8, 64'h0, 64'h0, 1);
        do_req(1, 0, 2'd3, 0, 64'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 2);
        check("dir_double", rrd64, 64'h0123_4567_89AB_CDEF);
        do_req(1, 0, 2'd0, 0, 64'h7, 64'h0, 64'h8000_0000_0000_0000, 1);

        // reset in the 2nd ACCESS cycle
        cur = 1'b0;
        @(negedge clk);
        req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 64'h100;
        req_valid32 = 1'b1;
        @(posedge clk); #1; req_valid32 = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_pre_req", {63'b0, o_mreq}, 64'd1);
        rst = 1'b1; #1;
        check("rst_mid_mem_req", {63'b0, o_mreq}, 64'd0);
        check("rst_mid_ready", {63'b0, o_ready}, 64'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_rv) seen++;
        end
        check("rst_mid_no_resp", 64'(seen), 64'd0);
        do_req(0, 0, 2'd0, 1, 64'h101, 64'h0, 64'h0000_C300, 2);

        // randomized traffic on both widths
        for (int i = 0; i < 80; i++) begin
            bit sel;
            logic [1:0] sz;
            logic [63:0] a;
            sel = (i % 3 == 2);
            sz  = 2'($urandom_range(0, 3));
            a   = rnd64();
            if (!sel) a = a & 64'hFFFF_FFFF;
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
            do_req(sel, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   rnd64(), rnd64(), $urandom_range(1, sel ? 17 : 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
